// File: rtl/spi_axi_lite_pkg.sv
// Shared types for the spi_axi_lite register slave and its SPI shift engine.
//   state_e : shift engine FSM states
//   cfg_t   : configuration bundle latched by the register slave
//   DATA_W_DEF / DIV_W_DEF : default word and divider widths
package spi_axi_lite_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int DIV_W_DEF  = 8;
  localparam int LEN_W_DEF  = $clog2(DATA_W_DEF);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } state_e;

  typedef struct packed {
    logic                 cpol;
    logic                 cpha;
    logic                 lsb_first;
    logic [LEN_W_DEF-1:0] len;
    logic [DIV_W_DEF-1:0] div;
  } cfg_t;

endpackage

// File: rtl/spi_axi_lite_clkdiv.sv
// Half-period divider for the SPI shift engine.
// The counter runs 0..div and wraps; tick is high in the wrap cycle, so one
// tick appears every div+1 cycles while en is high. clear forces the count
// to zero so the first tick after clear lands exactly div+1 cycles later.
//   clk, rst_n : clock, async active-low reset
//   en         : count enable
//   clear      : synchronous count clear (wins over en)
//   div        : half-period minus one
//   tick       : edge strobe
module spi_axi_lite_clkdiv
  import spi_axi_lite_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clear,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  assign tick = en && !clear && (cnt == div);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == div) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_axi_lite_shift_engine.sv
// SPI master shift engine fed by the spi_axi_lite AXI4-Lite register slave.
// Latches cfg_* and tx_data on start_valid&&start_ready, then runs
// SETUP -> SHIFT (2N sclk edges) -> HOLD -> GAP, each phase step being one
// half period H = cfg_div+1. rx_data/rx_valid appear on the first GAP cycle,
// (2N+2)*H cycles after acceptance; start_ready returns after (2N+3)*H.
//   ACLK, ARESETN            : clock, async active-low reset
//   cfg_cpol/cpha/lsb_first  : SPI mode and bit order
//   cfg_len, cfg_div         : length-1 and half-period-1
//   start_valid/start_ready  : transfer request handshake
//   tx_data, rx_data/rx_valid: transmit word, received word + strobe
//   busy                     : transfer in progress
//   sclk, mosi, miso, cs_n   : SPI pins
// Optional build macro SPI_MISO_SYNC_EN: route miso through a 2-flop
// synchronizer and sample 2 cycles after the capture edge (cfg_div>=2).
module spi_axi_lite_shift_engine
  import spi_axi_lite_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DIV_W  = DIV_W_DEF,
  parameter int LEN_W  = $clog2(DATA_W)
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  input  logic              cfg_cpol,
  input  logic              cfg_cpha,
  input  logic              cfg_lsb_first,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic [DATA_W-1:0] tx_data,
  output logic              rx_valid,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic              cs_n
);

  state_e state, state_nxt;

  // latched transfer context
  logic              cpha_q, lsb_q;
  logic [LEN_W-1:0]  len_q;
  logic [DIV_W-1:0]  div_q;
  logic [DATA_W-1:0] tx_q;

  logic              sclk_q, cs_n_q, mosi_q;
  logic [LEN_W:0]    edge_cnt;   // edges already issued, 0..2N-1
  logic [LEN_W-1:0]  tx_idx;     // index of the next bit to drive
  logic [DATA_W-1:0] rx_sr, rx_shifted, rx_data_q;
  logic              rx_valid_q;

  logic accept, tick, shift_tick, last_edge, odd_edge;
  logic drive_edge, sample_edge, do_sample, sample_bit, tx_bit;

  spi_axi_lite_clkdiv #(.DIV_W(DIV_W)) u_clkdiv (
    .clk   (ACLK),
    .rst_n (ARESETN),
    .en    (state != ST_IDLE),
    .clear (state == ST_IDLE),
    .div   (div_q),
    .tick  (tick)
  );

  assign accept      = start_valid && (state == ST_IDLE);
  assign shift_tick  = (state == ST_SHIFT) && tick;
  // edge number is edge_cnt+1, so an even count means an odd (leading) edge
  assign odd_edge    = ~edge_cnt[0];
  assign last_edge   = (edge_cnt == {len_q, 1'b1});
  assign drive_edge  = cpha_q ? odd_edge : (!odd_edge && !last_edge);
  assign sample_edge = cpha_q ? !odd_edge : odd_edge;
  assign tx_bit      = lsb_q ? tx_q[tx_idx] : tx_q[len_q - tx_idx];

`ifdef SPI_MISO_SYNC_EN
  logic [1:0] miso_sync;
  logic [1:0] samp_pend;   // sample point trails the capture edge by 2 cycles

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      miso_sync <= '0;
      samp_pend <= '0;
    end else begin
      miso_sync <= {miso_sync[0], miso};
      samp_pend <= {samp_pend[0], shift_tick && sample_edge};
    end
  end

  assign sample_bit = miso_sync[1];
  assign do_sample  = samp_pend[1];

  always_ff @(posedge ACLK) begin
    if (ARESETN && state != ST_IDLE)
      assert (div_q >= DIV_W'(2))
        else $error("SPI_MISO_SYNC_EN requires cfg_div >= 2");
  end
`else
  assign sample_bit = miso;
  assign do_sample  = shift_tick && sample_edge;
`endif

  // MSB-first shifts left into bit 0; LSB-first shifts right into bit N-1.
  // Either way N samples leave the word right-justified with zero above.
  always_comb begin
    rx_shifted = lsb_q ? (rx_sr >> 1) : (rx_sr << 1);
    if (lsb_q) rx_shifted[len_q] = sample_bit;
    else       rx_shifted[0]     = sample_bit;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept)              state_nxt = ST_SETUP;
      ST_SETUP: if (tick)                state_nxt = ST_SHIFT;
      ST_SHIFT: if (tick && last_edge)   state_nxt = ST_HOLD;
      ST_HOLD:  if (tick)                state_nxt = ST_GAP;
      ST_GAP:   if (tick)                state_nxt = ST_IDLE;
      default:                           state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      cpha_q     <= 1'b0;
      lsb_q      <= 1'b0;
      len_q      <= '0;
      div_q      <= '0;
      tx_q       <= '0;
      sclk_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      mosi_q     <= 1'b0;
      edge_cnt   <= '0;
      tx_idx     <= '0;
      rx_sr      <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      if (accept) begin
        cpha_q   <= cfg_cpha;
        lsb_q    <= cfg_lsb_first;
        len_q    <= cfg_len;
        div_q    <= cfg_div;
        tx_q     <= tx_data;
        sclk_q   <= cfg_cpol;
        cs_n_q   <= 1'b0;
        edge_cnt <= '0;
        rx_sr    <= '0;
        // CPHA=0 presents bit 0 during SETUP; CPHA=1 drives it on edge 1
        mosi_q   <= cfg_cpha ? 1'b0 : (cfg_lsb_first ? tx_data[0] : tx_data[cfg_len]);
        tx_idx   <= {{(LEN_W-1){1'b0}}, ~cfg_cpha};
      end
      if (shift_tick) begin
        sclk_q   <= ~sclk_q;
        edge_cnt <= edge_cnt + 1'b1;
        if (drive_edge) begin
          mosi_q <= tx_bit;
          tx_idx <= tx_idx + 1'b1;
        end
      end
      if (do_sample) rx_sr <= rx_shifted;
      if (state == ST_HOLD && tick) begin
        cs_n_q     <= 1'b1;
        mosi_q     <= 1'b0;
        rx_data_q  <= rx_sr;
        rx_valid_q <= 1'b1;
      end
    end
  end

  // idle sclk follows cfg_cpol live, but is forced low while in reset
  assign sclk        = (state == ST_IDLE) ? (cfg_cpol & ARESETN) : sclk_q;
  assign cs_n        = cs_n_q;
  assign mosi        = mosi_q;
  assign start_ready = (state == ST_IDLE);
  assign busy        = (state != ST_IDLE);
  assign rx_valid    = rx_valid_q;
  assign rx_data     = rx_data_q;

endmodule

// File: tb/tb_spi_axi_lite_shift_engine.sv
// Scoreboard bench for spi_axi_lite_shift_engine. An acceptance monitor
// pushes expected rx word, rx/ready cycle and frame shape; independent
// monitors pop and compare on rx_valid, start_ready rise and cs_n rise.
// miso is driven from mosi (straight or inverted) or held constant.
module tb_spi_axi_lite_shift_engine;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic        cfg_cpol = 1'b0, cfg_cpha = 1'b0, cfg_lsb_first = 1'b0;
  logic [4:0]  cfg_len = '0;
  logic [7:0]  cfg_div = '0;
  logic        start_valid = 1'b0;
  logic        start_ready;
  logic [31:0] tx_data = '0;
  logic        rx_valid;
  logic [31:0] rx_data;
  logic        busy, sclk, mosi, miso, cs_n;
  logic [1:0]  mmode = 2'd0;   // 0 loopback, 1 inverted loopback, 2 const 0, 3 const 1

  assign miso = (mmode == 2'd0) ? mosi : (mmode == 2'd1) ? ~mosi : (mmode == 2'd3);

  spi_axi_lite_shift_engine dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .cfg_cpol(cfg_cpol), .cfg_cpha(cfg_cpha), .cfg_lsb_first(cfg_lsb_first),
    .cfg_len(cfg_len), .cfg_div(cfg_div),
    .start_valid(start_valid), .start_ready(start_ready), .tx_data(tx_data),
    .rx_valid(rx_valid), .rx_data(rx_data), .busy(busy),
    .sclk(sclk), .mosi(mosi), .miso(miso), .cs_n(cs_n)
  );

  always #5 ACLK = ~ACLK;

  int cyc = 0;
  always @(posedge ACLK) cyc <= cyc + 1;

  typedef struct { logic [31:0] data; int cyc; } rx_exp_t;
  typedef struct { int n; int h; logic cpol; } frm_exp_t;

  rx_exp_t  rx_q[$];
  frm_exp_t frm_q[$];
  int       rdy_q[$];
  int checks = 0, failures = 0;
  int last_acc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_ge(input string name, input int act, input int min);
    checks++;
    if (act < min) begin
      failures++;
      $display("FAIL %s: got %0d expected at least %0d", name, act, min);
    end
  endtask

  // reference: what the slave must return given what miso does
  function automatic logic [31:0] model_rx(input logic [31:0] tx, input int n, input logic [1:0] mode);
    logic [31:0] m;
    m = (n == 32) ? 32'hFFFF_FFFF : ((32'h1 << n) - 32'h1);
    case (mode)
      2'd0:    return tx & m;
      2'd1:    return ~tx & m;
      2'd2:    return 32'h0;
      default: return m;
    endcase
  endfunction

  // acceptance monitor: build the expectation from the stimulus seen at the handshake
  int acc_n, acc_h;
  always @(negedge ACLK) begin
    if (ARESETN && start_valid && start_ready) begin
      acc_n = int'(cfg_len) + 1;
      acc_h = int'(cfg_div) + 1;
      rx_q.push_back('{model_rx(tx_data, acc_n, mmode), cyc + 1 + (2*acc_n + 2)*acc_h});
      frm_q.push_back('{acc_n, acc_h, cfg_cpol});
      rdy_q.push_back(cyc + 1 + (2*acc_n + 3)*acc_h);
      last_acc = cyc + 1;
    end
  end

  // rx monitor
  rx_exp_t rx_e;
  logic prev_rxv = 1'b0;
  always @(negedge ACLK) begin
    if (!ARESETN) prev_rxv = 1'b0;
    else begin
      if (prev_rxv) check("rx_valid_pulse", rx_valid, 0);
      if (rx_valid) begin
        if (rx_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_rx_valid: rx_data=0x%08h with none outstanding", rx_data);
        end else begin
          rx_e = rx_q.pop_front();
          check("rx_data", rx_data, rx_e.data);
          check("rx_latency_cycle", cyc, rx_e.cyc);
        end
      end
      prev_rxv = rx_valid;
    end
  end

  // ready monitor
  logic prev_rdy = 1'b1;
  always @(negedge ACLK) begin
    if (ARESETN && start_ready && !prev_rdy) begin
      if (rdy_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_ready_rise: at cycle %0d", cyc);
      end else check("ready_cycle", cyc, rdy_q.pop_front());
    end
    prev_rdy = ARESETN ? start_ready : 1'b1;
  end

  // frame monitor: cs_n low time, sclk edge count, idle level, cs_n high gap
  frm_exp_t cur_f;
  logic prev_cs = 1'b1, prev_sclk = 1'b0, in_frm = 1'b0, gap_vld = 1'b0;
  int low_cnt = 0, tgl = 0, hi_cnt = 0, prev_h = 0;
  always @(negedge ACLK) begin
    if (!ARESETN) begin
      in_frm = 1'b0; gap_vld = 1'b0; prev_cs = 1'b1; prev_sclk = sclk;
    end else begin
      if (!cs_n) begin
        if (prev_cs) begin
          if (gap_vld) check_ge("cs_n_high_gap", hi_cnt, prev_h + 1);
          gap_vld = 1'b0;
          if (frm_q.size() == 0) begin
            checks++; failures++; in_frm = 1'b0;
            $display("FAIL unexpected_frame: cs_n fell at cycle %0d", cyc);
          end else begin
            cur_f = frm_q.pop_front(); in_frm = 1'b1;
          end
          low_cnt = 1; tgl = 0;
        end else begin
          low_cnt++;
          if (sclk !== prev_sclk) tgl++;
        end
      end else begin
        if (!prev_cs && in_frm) begin
          check("cs_n_low_cycles", low_cnt, (2*cur_f.n + 2)*cur_f.h);
          check("sclk_edges", tgl, 2*cur_f.n);
          check("sclk_idle_level", sclk, cur_f.cpol);
          hi_cnt = 1; prev_h = cur_f.h; gap_vld = 1'b1; in_frm = 1'b0;
        end else hi_cnt++;
      end
      prev_cs = cs_n; prev_sclk = sclk;
    end
  end

  task automatic wait_accept();
    bit ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge ACLK);
      if (start_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL accept_timeout: start_ready stayed 0 for 3000 cycles");
    end
    @(posedge ACLK); #2;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge ACLK);
      if (start_ready && rx_q.size() == 0 && rdy_q.size() == 0 && frm_q.size() == 0) begin
        ok = 1'b1; break;
      end
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL idle_timeout: rx_q=%0d rdy_q=%0d frm_q=%0d", rx_q.size(), rdy_q.size(), frm_q.size());
    end
  endtask

  task automatic set_cfg(input logic cpol, input logic cpha, input logic lsb,
                         input logic [4:0] len, input logic [7:0] div,
                         input logic [31:0] tx, input logic [1:0] mode);
    cfg_cpol = cpol; cfg_cpha = cpha; cfg_lsb_first = lsb;
    cfg_len = len; cfg_div = div; tx_data = tx; mmode = mode;
  endtask

  task automatic xfer(input logic cpol, input logic cpha, input logic lsb,
                      input logic [4:0] len, input logic [7:0] div,
                      input logic [31:0] tx, input logic [1:0] mode);
    @(posedge ACLK); #2;
    set_cfg(cpol, cpha, lsb, len, div, tx, mode);
    start_valid = 1'b1;
    wait_accept();
    start_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  int a1, a2;
  initial begin
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    check("reset_sclk", sclk, 0);
    check("reset_cs_n", cs_n, 1);
    check("reset_mosi", mosi, 0);
    check("reset_busy", busy, 0);
    check("reset_rx_valid", rx_valid, 0);
    check("reset_rx_data", rx_data, 0);
    check("reset_start_ready", start_ready, 1);
    @(posedge ACLK); #2; ARESETN = 1'b1;

    // mode 0, H=2, 8 bits, loopback: rx_valid 36 cycles after acceptance
    xfer(0, 0, 0, 5'd7, 8'd1, 32'hA5, 2'd0);
    wait_idle();
    // mode 3, H=1, 32 bits LSB-first, loopback: rx_valid at 66
    xfer(1, 1, 1, 5'd31, 8'd0, 32'hDEADBEEF, 2'd0);
    wait_idle();
    // mode 1, single bit, miso forced low
    xfer(0, 1, 0, 5'd0, 8'd2, 32'h1, 2'd2);
    wait_idle();

    // start_valid held through a transfer, tx_data changed mid-flight
    @(posedge ACLK); #2;
    set_cfg(0, 0, 0, 5'd7, 8'd1, 32'h3C, 2'd0);
    start_valid = 1'b1;
    wait_accept(); a1 = last_acc;
    repeat (10) @(posedge ACLK); #2;
    tx_data = 32'h55;
    wait_accept(); a2 = last_acc;
    start_valid = 1'b0;
    check("held_valid_accept_spacing", a2 - a1, (2*8 + 3)*2 + 1);
    wait_idle();

    // back-to-back frames, H=4
    @(posedge ACLK); #2;
    set_cfg(1, 0, 0, 5'd5, 8'd3, $urandom, 2'd0);
    start_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_accept();
      tx_data = $urandom;
    end
    start_valid = 1'b0;
    wait_idle();

    // reset in the middle of SHIFT
    xfer(0, 0, 0, 5'd31, 8'd1, $urandom, 2'd0);
    repeat (20) @(posedge ACLK); #2;
    ARESETN = 1'b0;
    rx_q.delete(); frm_q.delete(); rdy_q.delete();
    #1;
    check("midrst_cs_n", cs_n, 1);
    check("midrst_sclk", sclk, 0);
    check("midrst_mosi", mosi, 0);
    check("midrst_busy", busy, 0);
    check("midrst_start_ready", start_ready, 1);
    check("midrst_rx_valid", rx_valid, 0);
    repeat (2) @(posedge ACLK); #2;
    ARESETN = 1'b1;
    repeat (150) @(posedge ACLK);
    xfer(1, 0, 1, 5'd15, 8'd2, $urandom, 2'd0);
    wait_idle();

    // randomized frames
    for (int k = 0; k < 14; k++) begin
      xfer(1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom_range(0, 31)),
           8'($urandom_range(0, 3)), $urandom, 2'($urandom_range(0, 3)));
      wait_idle();
    end

    repeat (10) @(posedge ACLK);
    check("drain_rx_q", rx_q.size(), 0);
    check("drain_rdy_q", rdy_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_axi_lite_shift_engine.md
Name: spi_axi_lite_shift_engine

Overview:
SPI master shift engine sitting directly downstream of the spi_axi_lite AXI4-Lite register slave. The register slave drives the latched configuration and a start request. The engine generates SCLK, CS_N and MOSI, samples MISO, and returns the received word with a one-cycle valid pulse for capture into the RX register. It runs entirely in the ACLK domain, with SCLK derived by a programmable divider.

Parameters:
DATA_W, 32, maximum transfer length in bits; also the tx/rx word width
DIV_W, 8, width of the SCLK half-period divider field
LEN_W, $clog2(DATA_W), width of the transfer-length field

Ports:
ACLK  in  1  system clock
ARESETN  in  1  reset; one clock, asynchronous assert, active-low
cfg_cpol  in  1  SCLK idle level
cfg_cpha  in  1  0 = sample on leading edge; 1 = sample on trailing edge
cfg_lsb_first  in  1  1 = bit 0 shifted first
cfg_len  in  LEN_W  transfer length minus one (N = cfg_len+1, range 1..DATA_W)
cfg_div  in  DIV_W  SCLK half-period minus one, in ACLK cycles (H = cfg_div+1)
start_valid  in  1  transfer request from the register slave
start_ready  out  1  engine idle, able to accept a request
tx_data  in  DATA_W  word to transmit
rx_valid  out  1  one-cycle pulse; rx_data is new
rx_data  out  DATA_W  received word, right-justified, upper bits zero
busy  out  1  transfer in progress
sclk  out  1  SPI clock
mosi  out  1  SPI data out
miso  in  1  SPI data in
cs_n  out  1  SPI chip select, active-low

Behaviour:
- Reset values: sclk=0, cs_n=1, mosi=0, busy=0, rx_valid=0, rx_data=0, start_ready=1.
- Reset mid-transfer: all outputs return to reset values immediately. No rx_valid is generated.
- Handshake:
  - start_ready = (state==IDLE).
  - A transfer is accepted on the cycle where start_valid&&start_ready.
  - All cfg_* fields and tx_data are latched at acceptance. Input changes during a transfer are ignored.
  - start_valid while busy is ignored, not queued.
- busy = (state!=IDLE).
- FSM states: IDLE, SETUP, SHIFT, HOLD, GAP.
  - IDLE: cs_n=1; sclk=cfg_cpol, tracking the input live; mosi=0.
  - Acceptance -> SETUP: cs_n=0, sclk=cpol. If CPHA=0, mosi presents the first bit. Duration H cycles.
  - SETUP -> SHIFT: 2N SCLK edges, one every H cycles.
    - Each edge toggles sclk.
    - CPHA=0: sample miso on odd edges (leading); drive the next bit on even edges, except after the final edge.
    - CPHA=1: drive on odd edges; sample on even edges.
  - SHIFT -> HOLD: after the 2N-th edge, sclk=cpol and cs_n stays 0 for H cycles.
  - HOLD -> GAP: cs_n=1, rx_data updated, rx_valid=1 for the first GAP cycle only. Duration H cycles.
  - GAP -> IDLE.
- Bit order:
  - MSB-first: transmit tx_data[N-1] down to tx_data[0]; the first received bit lands in rx_data[N-1].
  - LSB-first: transmit tx_data[0] upward; the first received bit lands in rx_data[0].
  - rx_data[DATA_W-1:N] = 0.
- Latency:
  - rx_valid asserts exactly (2N+2)*H cycles after the acceptance cycle.
  - start_ready reasserts (2N+3)*H cycles after acceptance.
  - Minimum cs_n high time between transfers is H+1 cycles.
- Divider: a half-period counter counts 0..cfg_div and wraps; an edge event occurs at the wrap. With cfg_div=0, an edge occurs every cycle (SCLK = ACLK/2).
- rx_data holds its value until the next rx_valid.

Optional Feature:
SPI_MISO_SYNC_EN
- Defined: miso passes through a 2-flop synchronizer before sampling. The sample point is delayed to 2 cycles after the capture edge. Legal only for cfg_div>=2; behaviour for cfg_div<2 is undefined and flagged by an assertion. Latency is unchanged.
- Undefined: miso is sampled directly in the edge cycle.

Decomposition:
- Shared package spi_axi_lite_pkg holds:
  - the state enum typedef;
  - localparams DATA_W_DEF=32 and DIV_W_DEF=8;
  - a cfg struct typedef {cpol, cpha, lsb_first, len, div}, which the register slave also uses.
- One sub-module: spi_axi_lite_clkdiv (half-period counter plus edge strobe with load/clear).

Test Plan:
- Mode 0, cfg_div=1, cfg_len=7, tx 0xA5, miso tied to mosi -> 16 sclk edges; rx_data=0x000000A5; rx_valid 36 cycles after acceptance.
- Mode 3 (cpol=1, cpha=1), cfg_div=0, cfg_len=31, LSB-first, tx 0xDEADBEEF, loopback -> sclk idles high; rx_data=0xDEADBEEF; rx_valid at cycle 66.
- Mode 1, cfg_len=0, tx 0x1, miso forced 0 -> single sclk pulse; rx_data=0; cs_n low for exactly 4*H cycles.
- start_valid held high during a transfer, with tx_data changed to 0x55 mid-transfer -> the original word is sent; the next acceptance occurs only when start_ready rises.
- ARESETN low midway through SHIFT -> cs_n=1 and sclk=0 the same cycle; no rx_valid; a fresh transfer after release completes normally.
- Back-to-back requests with cfg_div=3 -> cs_n high for at least 5 cycles between frames.
